// File: rtl/led_bank_scheduler_pkg.sv
// Shared types and helpers for the LED bank scheduler: FSM states, LED width and
// the round-robin picker used by the arbiter.
package led_bank_scheduler_pkg;

  localparam int LED_W   = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit scanning upward from last+1, wrapping at n_req.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0]         last,
                                    input int                 n_req);
    pick_t p;
    int    cand;
    p = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = (int'(last) + k) % n_req;
      if (!p.found && (k <= n_req) && req[cand[2:0]]) begin
        p.found = 1'b1;
        p.idx   = cand[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/led_bank_scheduler_if.sv
// Bundle between the pattern sources and the LED bank scheduler.
// Sources sit on the master side, the scheduler on the slave side.
interface led_bank_scheduler_if #(
  parameter int N_REQ = 4
);
  import led_bank_scheduler_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [LED_W*N_REQ-1:0] pat;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [LED_W-1:0]       led;

  modport master (
    output req,
    output pat,
    input  gnt,
    input  busy,
    input  led
  );

  modport slave (
    input  req,
    input  pat,
    output gnt,
    output busy,
    output led
  );

endinterface

// File: rtl/led_bank_scheduler_prescaler.sv
// Free-running prescaler shared by the LED blocks: exposes the counter MSB for the
// heartbeat and a one-clock tick when the counter is all ones.
module led_prescaler #(
  parameter int PRESC_BITS = 22
) (
  input  logic clk,
  input  logic rst_n,
  output logic presc_msb,
  output logic tick
);

  logic [PRESC_BITS-1:0] presc_q;
  logic [PRESC_BITS-1:0] presc_d;

  always_comb begin
    presc_d = presc_q + PRESC_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign presc_msb = presc_q[PRESC_BITS-1];
  assign tick      = &presc_q;

endmodule

// File: rtl/led_bank_scheduler.sv
// Round-robin owner of the 8-LED bank with a minimum dwell per owner; drives the
// heartbeat on LED7 when nobody asks for the bank.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner, LED7 shows prescaler MSB, arbitrating every clk
//   OWN     | owner = last_q, LED mirrors its pattern, dwell counts ticks
//   RELEASE | one blank clk between owners, arbitrates on current REQ
module led_bank_scheduler
  import led_bank_scheduler_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int PRESC_BITS  = 22,
  parameter int DWELL_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_bank_scheduler_if.slave  bus
);

  localparam int LW = $clog2(N_REQ);

  logic             presc_msb;
  logic             tick;

  state_t           state_q,  state_d;
  logic [N_REQ-1:0] gnt_q,    gnt_d;
  logic             busy_q,   busy_d;
  logic [LED_W-1:0] led_q,    led_d;
  logic [7:0]       dwell_q,  dwell_d;
  logic [LW-1:0]    last_q,   last_d;

  pick_t            pick;
  logic [N_REQ-1:0] owner_mask;
  logic             owner_req;
  logic             others_req;
  logic             dwell_done;
  logic [LED_W-1:0] owner_pat;
  logic [LED_W-1:0] win_pat;

  led_prescaler #(
    .PRESC_BITS (PRESC_BITS)
  ) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .presc_msb (presc_msb),
    .tick      (tick)
  );

  assign pick       = rr_pick(MAX_REQ'(bus.req), 3'(last_q), N_REQ);
  assign owner_mask = N_REQ'(1) << last_q;
  assign owner_req  = |(bus.req & owner_mask);
  assign others_req = |(bus.req & ~owner_mask);
  assign dwell_done = (dwell_q == 8'(DWELL_TICKS));
  assign owner_pat  = bus.pat[int'(last_q)*LED_W +: LED_W];
  assign win_pat    = bus.pat[int'(pick.idx)*LED_W +: LED_W];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    led_d   = led_q;
    dwell_d = dwell_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE, RELEASE: begin
        if (pick.found) begin
          state_d = OWN;
          gnt_d   = N_REQ'(1) << pick.idx;
          last_d  = LW'(pick.idx);
          dwell_d = '0;
          busy_d  = 1'b1;
          led_d   = win_pat;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          led_d   = {presc_msb, {(LED_W-1){1'b0}}};
        end
      end
      OWN: begin
        // A dropped request wins over an expired dwell; both lead to RELEASE.
        if (!owner_req || (dwell_done && others_req)) begin
          state_d = RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          led_d   = '0;
        end else begin
          led_d = owner_pat;
          if (tick && !dwell_done) begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      led_q   <= '0;
      dwell_q <= '0;
      last_q  <= LW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.led  = led_q;

endmodule

// File: tb/tb_led_bank_scheduler.sv
// Directed bench for led_bank_scheduler with a 4-bit prescaler (tick every 16 clk),
// dwell of 2 ticks and 4 requesters; expected values are worked out by clock count.
module tb_led_bank_scheduler;
  import led_bank_scheduler_pkg::*;

  localparam int N_REQ = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc;
  int   n_checks = 0;
  int   n_err    = 0;

  led_bank_scheduler_if #(.N_REQ(N_REQ)) bus ();

  led_bank_scheduler #(
    .N_REQ       (N_REQ),
    .PRESC_BITS  (4),
    .DWELL_TICKS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edges since reset release; prescaler value after edge k is k mod 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) check_val("sync", cyc, n);
  endtask

  task automatic set_pat(input int i, input logic [7:0] v);
    bus.pat[8*i +: 8] = v;
  endtask

  // Called #1 after an edge: reset lands between edges and is checked before the next one.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_val({tag, "_rst_gnt"},  bus.gnt,  0);
    check_val({tag, "_rst_busy"}, bus.busy, 0);
    check_val({tag, "_rst_led"},  bus.led,  0);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0;
    bus.pat = '0;
    repeat (2) @(posedge clk);
    #1;

    // 1: heartbeat only
    do_reset("t1");
    for (int k = 1; k <= 64; k++) begin
      goto(k);
      check_val("t1_led", bus.led, (((k - 1) % 16) >= 8) ? 32'h80 : 32'h00);
    end
    check_val("t1_gnt",  bus.gnt,  0);
    check_val("t1_busy", bus.busy, 0);

    // 2: single requester, pattern follow
    bus.req = 4'b0100;
    set_pat(2, 8'hA5);
    check_val("t2_gnt_lag", bus.gnt, 0);
    goto(65);
    check_val("t2_gnt",  bus.gnt,  4'b0100);
    check_val("t2_busy", bus.busy, 1);
    check_val("t2_led",  bus.led,  8'hA5);
    set_pat(2, 8'h3C);
    check_val("t2_led_hold", bus.led, 8'hA5);
    goto(66);
    check_val("t2_led_new", bus.led, 8'h3C);
    bus.req = 4'b0000;
    goto(67);
    check_val("t2_rel_gnt",  bus.gnt,  0);
    check_val("t2_rel_busy", bus.busy, 0);
    check_val("t2_rel_led",  bus.led,  0);
    goto(68);
    check_val("t2_idle_gnt", bus.gnt, 0);

    // 3: owner 0 keeps the bank for two ticks while 1 waits
    bus.req = 4'b0001;
    set_pat(0, 8'h5A);
    set_pat(1, 8'hC3);
    goto(69);
    check_val("t3_gnt0", bus.gnt, 4'b0001);
    check_val("t3_led0", bus.led, 8'h5A);
    bus.req = 4'b0011;
    goto(80);
    check_val("t3_tick1", bus.gnt, 4'b0001);
    goto(96);
    check_val("t3_tick2", bus.gnt, 4'b0001);
    goto(97);
    check_val("t3_blank_gnt", bus.gnt, 0);
    check_val("t3_blank_led", bus.led, 0);
    goto(98);
    check_val("t3_gnt1", bus.gnt, 4'b0010);
    check_val("t3_led1", bus.led, 8'hC3);

    // 4: everyone requests, round robin with one blank cycle per handover
    do_reset("t4");
    bus.req = 4'b1111;
    set_pat(0, 8'h11);
    set_pat(1, 8'h22);
    set_pat(2, 8'h44);
    set_pat(3, 8'h88);
    begin
      int          t_cyc [15] = '{1, 32, 33, 34, 65, 66, 97, 98, 129, 130, 161, 162, 289, 290, 300};
      logic [3:0]  t_gnt [15] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                                  4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0010,
                                  4'b0010};
      logic [7:0]  t_led [15] = '{8'h11, 8'h11, 8'h00, 8'h22, 8'h00, 8'h44, 8'h00,
                                  8'h88, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h22, 8'h22};
      for (int i = 0; i < 15; i++) begin
        goto(t_cyc[i]);
        check_val($sformatf("t4_gnt_%0d", t_cyc[i]), bus.gnt, t_gnt[i]);
        check_val($sformatf("t4_led_%0d", t_cyc[i]), bus.led, t_led[i]);
      end
    end

    // 5: owner drops on its second tick, then a sole owner keeps the bank
    do_reset("t5");
    bus.req = 4'b1010;
    set_pat(1, 8'h77);
    set_pat(3, 8'hE7);
    goto(1);
    check_val("t5_gnt1", bus.gnt, 4'b0010);
    goto(31);
    check_val("t5_gnt1_hold", bus.gnt, 4'b0010);
    bus.req = 4'b1000;
    goto(32);
    check_val("t5_blank_gnt",  bus.gnt,  0);
    check_val("t5_blank_led",  bus.led,  0);
    check_val("t5_blank_busy", bus.busy, 0);
    goto(33);
    check_val("t5_gnt3", bus.gnt, 4'b1000);
    check_val("t5_led3", bus.led, 8'hE7);
    goto(153);
    check_val("t5_sole_gnt",  bus.gnt,  4'b1000);
    check_val("t5_sole_busy", bus.busy, 1);
    set_pat(3, 8'h18);
    goto(154);
    check_val("t5_sole_led", bus.led, 8'h18);

    // 6: async reset while owned, then heartbeat and source 0 priority
    do_reset("t6");
    bus.req = 4'b0000;
    goto(8);
    check_val("t6_hb_lo",  bus.led, 8'h00);
    check_val("t6_hb_gnt", bus.gnt, 0);
    goto(9);
    check_val("t6_hb_hi", bus.led, 8'h80);
    bus.req = 4'b1001;
    set_pat(0, 8'h0F);
    goto(10);
    check_val("t6_prio_gnt", bus.gnt, 4'b0001);
    check_val("t6_prio_led", bus.led, 8'h0F);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
